// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state codes, mode encodings and widths for the run/step controller.
package cpu_run_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_RST_HOLD = 3'd0,
      ST_HALT     = 3'd1,
      ST_RUN      = 3'd2,
      ST_STEP     = 3'd3,
      ST_RUNN     = 3'd4
   } run_state_e;

   localparam logic [1:0] MODE_HALT = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;
   localparam logic [1:0] MODE_RUNN = 2'b11;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Controller <-> processor core signals: reset, clock enable, PC and completion pulse.
interface cpu_run_ctrl_if #(
   parameter int PC_WIDTH = 8
);
   // Handshake: cpu_instr_done is a one-cycle pulse from the core; it only counts
   // in a cycle where cpu_clk_en is high, otherwise the controller ignores it.
   logic [PC_WIDTH-1:0] cpu_pc;
   logic                cpu_instr_done;
   logic                cpu_reset_n;
   logic                cpu_clk_en;

   modport master (
      input  cpu_pc,
      input  cpu_instr_done,
      output cpu_reset_n,
      output cpu_clk_en
   );

   modport slave (
      output cpu_pc,
      output cpu_instr_done,
      input  cpu_reset_n,
      input  cpu_clk_en
   );
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller producing the core's reset and clock enable, with display counters.
// Optional PC breakpoint halt in RUN/RUNN is enabled by defining CPU_RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int PC_WIDTH  = 8,
   parameter int CNT_WIDTH = 16,
   parameter int RST_HOLD  = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [1:0]           mode,
   input  logic                 go,
   input  logic [CNT_WIDTH-1:0] run_count,
   input  logic                 clear_counts,
   cpu_run_ctrl_if.master       cpu,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
   input  logic                 bp_enable,
   input  logic [PC_WIDTH-1:0]  bp_addr,
`endif
   output logic                 running,
   output logic [STATE_W-1:0]   state,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count
);

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

   run_state_e           state_q, state_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
   logic                 go_q, go_rise_q;
   logic                 bp_hit;
   logic                 clk_en, core_rst_n;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
   assign bp_hit = cpu.cpu_instr_done & bp_enable & (cpu.cpu_pc == bp_addr);
`else
   assign bp_hit = 1'b0;
`endif

   // go_q resets high so a go level held through reset never reads as a rising edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_RST_HOLD;
         hold_q      <= '0;
         remaining_q <= '0;
         go_q        <= 1'b1;
         go_rise_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         remaining_q <= remaining_d;
         go_q        <= go;
         go_rise_q   <= go & ~go_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_RST_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = ST_HALT;
            else                     hold_d  = hold_q + 1'b1;
         end
         ST_HALT: begin
            if (go_rise_q) begin
               case (mode)
                  MODE_RUN:  state_d = ST_RUN;
                  MODE_STEP: state_d = ST_STEP;
                  MODE_RUNN: begin
                     if (run_count != '0) begin
                        state_d     = ST_RUNN;
                        remaining_d = run_count;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if ((mode == MODE_HALT) || bp_hit) state_d = ST_HALT;
         end
         ST_STEP: begin
            if ((mode == MODE_HALT) || cpu.cpu_instr_done) state_d = ST_HALT;
         end
         ST_RUNN: begin
            if (cpu.cpu_instr_done) remaining_d = remaining_q - 1'b1;
            if ((mode == MODE_HALT) || bp_hit ||
                (cpu.cpu_instr_done && (remaining_q == CNT_WIDTH'(1))))
               state_d = ST_HALT;
         end
         default: state_d = ST_HALT;
      endcase
   end

   // Core-facing outputs decode the registered state only, so they are glitch-free.
   assign core_rst_n      = (state_q != ST_RST_HOLD);
   assign clk_en          = (state_q != ST_HALT);
   assign running         = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_RUNN);
   assign state           = state_q;
   assign cpu.cpu_reset_n = core_rst_n;
   assign cpu.cpu_clk_en  = clk_en;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (clk_en & core_rst_n),
      .clr   (clear_counts),
      .count (cycle_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (cpu.cpu_instr_done & clk_en),
      .clr   (clear_counts),
      .count (instr_count)
   );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl (CNT_WIDTH=4 so saturation is reachable quickly).
module tb_cpu_run_ctrl;
   import cpu_run_ctrl_pkg::*;

   localparam int PC_W  = 8;
   localparam int CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic [1:0]       mode;
   logic             go;
   logic [CNT_W-1:0] run_count;
   logic             clear_counts;
   logic             running;
   logic [2:0]       state;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instr_count;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
   logic             bp_enable;
   logic [PC_W-1:0]  bp_addr;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   cpu_run_ctrl_if #(.PC_WIDTH(PC_W)) cpu_bus ();

   cpu_run_ctrl #(.PC_WIDTH(PC_W), .CNT_WIDTH(CNT_W), .RST_HOLD(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .mode         (mode),
      .go           (go),
      .run_count    (run_count),
      .clear_counts (clear_counts),
      .cpu          (cpu_bus),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      .bp_enable    (bp_enable),
      .bp_addr      (bp_addr),
`endif
      .running      (running),
      .state        (state),
      .cycle_count  (cycle_count),
      .instr_count  (instr_count)
   );

   // clock / reset
   always #5 clock = ~clock;

   // driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic go_start(input logic [1:0] m, input logic [CNT_W-1:0] n);
      mode      = m;
      run_count = n;
      go        = 1'b1;
      tick();
      go = 1'b0;
      tick();
   endtask

   task automatic clear_cnt();
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      mode = MODE_HALT;
      go = 1'b0;
      run_count = '0;
      clear_counts = 1'b0;
      cpu_bus.cpu_pc = '0;
      cpu_bus.cpu_instr_done = 1'b0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      bp_enable = 1'b0;
      bp_addr = '0;
`endif
      repeat (3) tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_reset_n", 32'(cpu_bus.cpu_reset_n), 32'd0);
      check("rst_clk_en", 32'(cpu_bus.cpu_clk_en), 32'd1);
      check("rst_running", 32'(running), 32'd0);
      check("rst_cycles", 32'(cycle_count), 32'd0);

      // reset release: core reset held exactly two cycles
      reset = 1'b1;
      tick();
      check("hold1_reset_n", 32'(cpu_bus.cpu_reset_n), 32'd0);
      check("hold1_state", 32'(state), 32'd0);
      tick();
      check("halt_state", 32'(state), 32'd1);
      check("halt_reset_n", 32'(cpu_bus.cpu_reset_n), 32'd1);
      check("halt_clk_en", 32'(cpu_bus.cpu_clk_en), 32'd0);
      check("halt_cycles", 32'(cycle_count), 32'd0);
      check("halt_instrs", 32'(instr_count), 32'd0);

      // single step: enable rises two edges after go, done on 4th enabled cycle
      mode = MODE_STEP;
      go = 1'b1;
      tick();
      go = 1'b0;
      check("step_detect_en", 32'(cpu_bus.cpu_clk_en), 32'd0);
      exp_q = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0};
      for (int i = 0; i < 5; i++) begin
         tick();
         cpu_bus.cpu_instr_done = 1'b0;
         check("step_en", 32'(cpu_bus.cpu_clk_en), exp_q.pop_front());
         if (i == 3) cpu_bus.cpu_instr_done = 1'b1;
      end
      check("step_state", 32'(state), 32'd1);
      check("step_instrs", 32'(instr_count), 32'd1);
      check("step_cycles", 32'(cycle_count), 32'd4);

      clear_cnt();
      check("clear_cycles", 32'(cycle_count), 32'd0);
      check("clear_instrs", 32'(instr_count), 32'd0);

      // run-N with N=3, instruction every 4 cycles
      go_start(MODE_RUNN, 4'd3);
      for (int j = 1; j <= 12; j++) begin
         check("runn_en", 32'(cpu_bus.cpu_clk_en), 32'd1);
         if (j == 1) check("runn_state", 32'(state), 32'd4);
         cpu_bus.cpu_instr_done = (j % 4 == 0);
         tick();
         cpu_bus.cpu_instr_done = 1'b0;
      end
      check("runn_end_state", 32'(state), 32'd1);
      check("runn_end_en", 32'(cpu_bus.cpu_clk_en), 32'd0);
      check("runn_instrs", 32'(instr_count), 32'd3);
      check("runn_cycles", 32'(cycle_count), 32'd12);

      // run-N with N=0 never starts
      go_start(MODE_RUNN, 4'd0);
      for (int k = 0; k < 4; k++) begin
         check("runn0_en", 32'(cpu_bus.cpu_clk_en), 32'd0);
         check("runn0_state", 32'(state), 32'd1);
         tick();
      end

      // free run saturates the 4-bit cycle counter
      clear_cnt();
      go_start(MODE_RUN, 4'd0);
      check("run_state", 32'(state), 32'd2);
      check("run_running", 32'(running), 32'd1);
      repeat (20) tick();
      check("run_sat", 32'(cycle_count), 32'd15);
      clear_cnt();
      check("clr_vs_inc", 32'(cycle_count), 32'd0);
      mode = MODE_HALT;
      tick();
      check("run_stop_state", 32'(state), 32'd1);

      // reset mid-run with go held high through release
      go_start(MODE_RUN, 4'd0);
      tick();
      check("run2_state", 32'(state), 32'd2);
      go = 1'b1;
      reset = 1'b0;
      tick();
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_reset_n", 32'(cpu_bus.cpu_reset_n), 32'd0);
      check("midrst_running", 32'(running), 32'd0);
      check("midrst_cycles", 32'(cycle_count), 32'd0);
      reset = 1'b1;
      repeat (2) tick();
      check("rel_state", 32'(state), 32'd1);
      repeat (3) tick();
      check("go_held_state", 32'(state), 32'd1);
      check("go_held_en", 32'(cpu_bus.cpu_clk_en), 32'd0);
      go = 1'b0;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      bp_enable = 1'b1;
      bp_addr = 8'h05;
      go_start(MODE_RUN, 4'd0);
      cpu_bus.cpu_pc = 8'h04;
      cpu_bus.cpu_instr_done = 1'b1;
      tick();
      cpu_bus.cpu_instr_done = 1'b0;
      check("bp_miss_state", 32'(state), 32'd2);
      cpu_bus.cpu_pc = 8'h05;
      cpu_bus.cpu_instr_done = 1'b1;
      tick();
      cpu_bus.cpu_instr_done = 1'b0;
      check("bp_hit_state", 32'(state), 32'd1);
      check("bp_instrs", 32'(instr_count), 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run/step controller for the multicycle processor. It generates the processor's active-low reset and a clock enable, giving free-run, single-instruction step and run-N-instructions modes. It also keeps saturating cycle and instruction counters for the HEX/LEDR display. It replaces hand-sequenced reset/KEY stimulus with a parametrised on-chip block between board inputs (SW/KEY) and the processor core.

Parameters:
PC_WIDTH, 8, width of processor PC observed for breakpoints
CNT_WIDTH, 16, width of run_count, cycle_count, instr_count
RST_HOLD, 2, cycles (>=1) cpu_reset_n is held low after controller reset release

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-low; sampled on rising edge of clock
mode  in  2  00 halt, 01 run, 10 step, 11 run-N
go  in  1  level; rising edge starts the selected mode from HALT
run_count  in  CNT_WIDTH  instruction count for run-N, sampled on go edge
clear_counts  in  1  synchronous clear of cycle_count/instr_count
cpu_pc  in  PC_WIDTH  processor PC
cpu_instr_done  in  1  one-cycle pulse when processor completes an instruction
cpu_reset_n  out  1  processor reset, active-low
cpu_clk_en  out  1  processor clock enable
running  out  1  high in RUN, STEP, RUNN
state  out  3  current state code, for LEDR
cycle_count  out  CNT_WIDTH  enabled processor cycles, saturating
instr_count  out  CNT_WIDTH  completed instructions, saturating

Behaviour:
- Reset (reset==0 at edge): state=RST_HOLD, hold counter=0, remaining=0, go_q=1, cycle_count=0, instr_count=0; registered outputs cpu_reset_n=0, cpu_clk_en=1, running=0. Applies mid-operation from any state.
- States: RST_HOLD=0, HALT=1, RUN=2, STEP=3, RUNN=4.
- RST_HOLD: cpu_reset_n=0, cpu_clk_en=1, so the core's sync reset is clocked. After exactly RST_HOLD cycles go to HALT.
- HALT: cpu_reset_n=1, cpu_clk_en=0.
- go_rise = go & ~go_q, registered edge detect. It is acted on only in HALT and ignored elsewhere. go held high through reset produces no start.
- HALT on go_rise:
  - mode 01 -> RUN.
  - mode 10 -> STEP.
  - mode 11 with run_count!=0 -> RUNN, remaining=run_count.
  - mode 11 with run_count==0 -> stay HALT.
  - mode 00 -> stay HALT.
- RUN: cpu_clk_en=1. Go to HALT the cycle after mode==00 is sampled.
- STEP: cpu_clk_en=1 until cpu_instr_done is sampled. That cycle keeps en=1, then next state is HALT. mode==00 aborts to HALT.
- RUNN: cpu_clk_en=1.
  - remaining decrements on each cpu_instr_done.
  - instr_done with remaining==1 -> HALT.
  - mode==00 aborts to HALT, remaining kept.
- Timing: outputs are a combinational decode of the registered state. cpu_clk_en rises the cycle after go_rise is detected, 2 cycles after go rises.
- cycle_count: +1 every cycle with cpu_clk_en & cpu_reset_n.
- instr_count: +1 on cpu_instr_done & cpu_clk_en.
- Both counters saturate at all-ones and never wrap.
- clear_counts has priority over increment in the same cycle.
- cpu_instr_done while cpu_clk_en==0 is ignored.

Optional Feature:
CPU_RUN_CTRL_BREAKPOINT_EN:
- Adds inputs bp_enable (1) and bp_addr (PC_WIDTH).
- In RUN/RUNN, cpu_instr_done with bp_enable and cpu_pc==bp_addr -> HALT next cycle. The instruction is counted.
- STEP is unaffected.
- Without the macro: no bp ports and no compare logic; RUN halts only via mode.

Decomposition:
- Package cpu_run_ctrl_pkg: state code constants (RST_HOLD..RUNN), mode encodings (MODE_HALT/RUN/STEP/RUNN), state width 3.
- One sub-module sat_counter (param WIDTH; inc, clr inputs; clr wins), instantiated twice.

Test Plan:
- RST_HOLD=2, release reset -> cpu_reset_n low exactly 2 cycles, then HALT (state=1), cpu_clk_en=0, counters 0.
- mode=10, go pulse, instr_done every 4 cycles -> cpu_clk_en high 4 cycles, HALT, instr_count=1, cycle_count=4.
- mode=11, run_count=3, instr_done every 4 cycles -> 12 enabled cycles, HALT, instr_count=3.
- mode=11, run_count=0, go -> stays HALT, cpu_clk_en never 1.
- mode=01 run, reset low mid-run -> next edge state=RST_HOLD, cpu_reset_n=0, counters 0; go held high through release causes no start.
- CNT_WIDTH=4, run 20 cycles -> cycle_count saturates at 15. clear_counts with an increment in the same cycle -> 0. With BREAKPOINT_EN, bp_addr=8'h05, pc reaches 5 on instr_done -> HALT next cycle.
